if_fetch_unit: RTL and testbench

- Instruction-fetch initiator paired with the combinational instruction memory.
- Owns the architectural PC and drives it to the memory as the read address. Captures the returned word into the IF/ID pipeline register.
- Handles stall, branch/jump redirects with one MIPS delay slot, exception entry to the handler, and eret return.
- Sits between CP0/hazard control and the decode stage.

---
 rtl/mips_defs_pkg.sv | 31 +++
 rtl/if_npc_sel.sv | 38 +++
 rtl/if_fetch_unit.sv | 95 +++++++++
 tb/tb_if_fetch_unit.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs_pkg.sv
// Shared MIPS fetch-side constants, exception codes and the next-PC source
// type used by the fetch unit and its next-PC selector.
package mips_defs;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] TEXT_BASE  = 32'h0000_3000;
    localparam logic [31:0] TEXT_LIMIT = 32'h0000_6FFC;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_INT  = 5'd0;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [2:0] {
        NPC_EXC,
        NPC_ERET,
        NPC_HOLD,
        NPC_REDIRECT,
        NPC_SEQ
    } npc_src_e;

    // A fetch is illegal when misaligned or outside the text segment.
    function automatic logic fetch_addr_bad(input logic [31:0] pc,
                                            input logic [31:0] base,
                                            input logic [31:0] limit);
        return (pc[1:0] != 2'b00) || (pc < base) || (pc > limit);
    endfunction

endpackage

// File: rtl/if_npc_sel.sv
// Combinational next-PC priority mux: exception, eret, stall, redirect,
// then sequential fetch. Also reports which source won.
module if_npc_sel
    import mips_defs::*;
#(
    parameter logic [31:0] HANDLER_PC = mips_defs::HANDLER_PC
) (
    input  logic [31:0] pc,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] npc,
    output npc_src_e    src
);

    always_comb begin
        src = NPC_SEQ;
        npc = pc + 32'd4;
        if (exc_req) begin
            src = NPC_EXC;
            npc = HANDLER_PC;
        end else if (eret_req) begin
            src = NPC_ERET;
            npc = epc;
        end else if (stall) begin
            // A redirect seen during a stall is dropped; hazard logic re-presents it.
            src = NPC_HOLD;
            npc = pc;
        end else if (redirect_valid) begin
            src = NPC_REDIRECT;
            npc = redirect_pc;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, delay-slot
// tagging and flush. Define FETCH_ADDR_CHECK_EN to enable fetch AdEL detection.
module if_fetch_unit
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC   = mips_defs::RESET_PC,
    parameter logic [31:0] HANDLER_PC = mips_defs::HANDLER_PC,
    parameter logic [31:0] TEXT_BASE  = mips_defs::TEXT_BASE,
    parameter logic [31:0] TEXT_LIMIT = mips_defs::TEXT_LIMIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] im_pc,
    input  logic [31:0] im_instr,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic [31:0] d_pc8,
    output logic        d_valid,
    output logic        d_bd,
    output logic [4:0]  d_exc_code
);

`ifdef FETCH_ADDR_CHECK_EN
    localparam logic ADDR_CHECK = 1'b1;
`else
    localparam logic ADDR_CHECK = 1'b0;
`endif

    logic [31:0] pc;
    logic [31:0] npc;
    npc_src_e    src;
    logic        fetch_bad;
    logic [31:0] fetch_word;
    logic [4:0]  fetch_exc;

    if_npc_sel #(
        .HANDLER_PC(HANDLER_PC)
    ) u_npc_sel (
        .pc            (pc),
        .exc_req       (exc_req),
        .eret_req      (eret_req),
        .epc           (epc),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .npc           (npc),
        .src           (src)
    );

    // With the check disabled the bad flag is constant 0, so the word passes through.
    assign fetch_bad  = ADDR_CHECK && fetch_addr_bad(pc, TEXT_BASE, TEXT_LIMIT);
    assign fetch_word = fetch_bad ? NOP_WORD : im_instr;
    assign fetch_exc  = fetch_bad ? EXC_ADEL : EXC_NONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc         <= RESET_PC;
            d_instr    <= NOP_WORD;
            d_pc       <= RESET_PC;
            d_valid    <= 1'b0;
            d_bd       <= 1'b0;
            d_exc_code <= EXC_NONE;
        end else begin
            pc <= npc;
            case (src)
                NPC_EXC, NPC_ERET: begin
                    d_instr    <= NOP_WORD;
                    d_pc       <= npc;
                    d_valid    <= 1'b0;
                    d_bd       <= 1'b0;
                    d_exc_code <= EXC_NONE;
                end
                NPC_HOLD: begin
                end
                default: begin
                    d_instr    <= fetch_word;
                    d_pc       <= pc;
                    d_valid    <= 1'b1;
                    d_bd       <= (src == NPC_REDIRECT);
                    d_exc_code <= fetch_exc;
                end
            endcase
        end
    end

    assign im_pc = pc;
    assign d_pc8 = d_pc + 32'd8;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus randomized
// traffic compared against a per-edge behavioural model of the fetch stage.
module tb_if_fetch_unit;

`ifdef FETCH_ADDR_CHECK_EN
    localparam logic ADDR_CHECK = 1'b1;
`else
    localparam logic ADDR_CHECK = 1'b0;
`endif

    typedef logic [135:0] snap_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        exc_req = 1'b0;
    logic        eret_req = 1'b0;
    logic [31:0] epc = 32'h0;
    logic [31:0] im_pc;
    logic [31:0] im_instr;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [31:0] d_pc8;
    logic        d_valid;
    logic        d_bd;
    logic [4:0]  d_exc_code;

    int total = 0;
    int bad = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_dpc;
    logic        m_valid;
    logic        m_bd;
    logic [4:0]  m_exc;

    if_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .exc_req       (exc_req),
        .eret_req      (eret_req),
        .epc           (epc),
        .im_pc         (im_pc),
        .im_instr      (im_instr),
        .d_instr       (d_instr),
        .d_pc          (d_pc),
        .d_pc8         (d_pc8),
        .d_valid       (d_valid),
        .d_bd          (d_bd),
        .d_exc_code    (d_exc_code)
    );

    always #5 clk = ~clk;

    // Address-dependent memory contents so a wrong fetch address shows up.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign im_instr = mem_word(im_pc);

    function automatic snap_t obs();
        return {im_pc, d_instr, d_pc, d_pc8, d_valid, d_bd, d_exc_code};
    endfunction

    function automatic snap_t expv();
        return {m_pc, m_instr, m_dpc, m_dpc + 32'd8, m_valid, m_bd, m_exc};
    endfunction

    task automatic model_reset();
        m_pc    = 32'h0000_3000;
        m_instr = 32'h0;
        m_dpc   = 32'h0000_3000;
        m_valid = 1'b0;
        m_bd    = 1'b0;
        m_exc   = 5'd0;
    endtask

    task automatic model_flush(input logic [31:0] target);
        m_pc    = target;
        m_dpc   = target;
        m_instr = 32'h0;
        m_valid = 1'b0;
        m_bd    = 1'b0;
        m_exc   = 5'd0;
    endtask

    // One clock edge of the fetch stage as described behaviourally.
    task automatic model_edge();
        logic fbad;
        if (exc_req) begin
            model_flush(32'h0000_4180);
        end else if (eret_req) begin
            model_flush(epc);
        end else if (!stall) begin
            fbad = ADDR_CHECK && ((m_pc % 4) != 0 || m_pc < 32'h0000_3000 || m_pc > 32'h0000_6FFC);
            m_dpc   = m_pc;
            m_valid = 1'b1;
            m_bd    = redirect_valid;
            m_instr = fbad ? 32'h0 : mem_word(m_pc);
            m_exc   = fbad ? 5'd4 : 5'd0;
            m_pc    = redirect_valid ? redirect_pc : m_pc + 32'd4;
        end
    endtask

    task automatic applyStimulus(input logic e, input logic er, input logic st,
                                 input logic rv, input logic [31:0] rpc,
                                 input logic [31:0] ep);
        exc_req        = e;
        eret_req       = er;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        epc            = ep;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        if (obs() !== expv()) begin
            bad++;
            $display("[TB] FAIL reset_state got=%h want=%h", obs(), expv());
        end
        total++;
        if (d_pc8 !== 32'h0000_3008) begin
            bad++;
            $display("[TB] FAIL reset_pc8 got=%h want=%h", d_pc8, 32'h0000_3008);
        end
        total++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 2; i++) begin
            applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
            if (obs() !== expv()) begin
                bad++;
                $display("[TB] FAIL seq[%0d] got=%h want=%h", i, obs(), expv());
            end
            total++;
            if (im_pc !== 32'h0000_3000 + 32'(4 * i) || d_valid !== 1'b1 || d_bd !== 1'b0) begin
                bad++;
                $display("[TB] FAIL seq_pc[%0d] got=%h/%b/%b want=%h/1/0", i, im_pc, d_valid, d_bd,
                         32'h0000_3000 + 32'(4 * i));
            end
            total++;
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 1, i[0], 32'h0000_3500, 32'h0);
            if (obs() !== expv() || im_pc !== 32'h0000_3008 || d_pc !== 32'h0000_3004) begin
                bad++;
                $display("[TB] FAIL stall[%0d] got=%h want=%h", i, obs(), expv());
            end
            total++;
        end
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
        if (obs() !== expv() || d_pc !== 32'h0000_3008 || im_pc !== 32'h0000_300C) begin
            bad++;
            $display("[TB] FAIL stall_release got=%h want=%h", obs(), expv());
        end
        total++;
    endtask

    task automatic test_redirect();
        applyStimulus(0, 0, 0, 1, 32'h0000_3100, 32'h0);
        if (obs() !== expv() || d_pc !== 32'h0000_300C || d_bd !== 1'b1 || im_pc !== 32'h0000_3100) begin
            bad++;
            $display("[TB] FAIL redirect_slot got=%h want=%h", obs(), expv());
        end
        total++;
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
        if (obs() !== expv() || d_pc !== 32'h0000_3100 || d_bd !== 1'b0) begin
            bad++;
            $display("[TB] FAIL redirect_target got=%h want=%h", obs(), expv());
        end
        total++;
    endtask

    task automatic test_exception();
        applyStimulus(1, 0, 1, 1, 32'h0000_3200, 32'h0);
        if (obs() !== expv() || im_pc !== 32'h0000_4180 || d_valid !== 1'b0 || d_instr !== 32'h0) begin
            bad++;
            $display("[TB] FAIL exc_entry got=%h want=%h", obs(), expv());
        end
        total++;
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
        if (obs() !== expv() || d_pc !== 32'h0000_4180 || d_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL exc_handler_fetch got=%h want=%h", obs(), expv());
        end
        total++;
        applyStimulus(1, 1, 0, 0, 32'h0, 32'h0000_3040);
        if (obs() !== expv() || im_pc !== 32'h0000_4180) begin
            bad++;
            $display("[TB] FAIL exc_over_eret got=%h want=%h", obs(), expv());
        end
        total++;
    endtask

    task automatic test_eret();
        applyStimulus(0, 1, 1, 1, 32'h0000_3300, 32'h0000_3020);
        if (obs() !== expv() || im_pc !== 32'h0000_3020 || d_valid !== 1'b0 || d_pc !== 32'h0000_3020) begin
            bad++;
            $display("[TB] FAIL eret_flush got=%h want=%h", obs(), expv());
        end
        total++;
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
        if (obs() !== expv() || d_pc !== 32'h0000_3020 || d_valid !== 1'b1 || d_bd !== 1'b0) begin
            bad++;
            $display("[TB] FAIL eret_fetch got=%h want=%h", obs(), expv());
        end
        total++;
    endtask

    task automatic test_addr_check();
        logic [31:0] targets [4];
        logic [4:0]  want_exc;
        targets[0] = 32'h0000_3002;
        targets[1] = 32'h0000_7000;
        targets[2] = 32'h0000_6FFC;
        targets[3] = 32'h0000_2FFC;
        for (int t = 0; t < 4; t++) begin
            applyStimulus(0, 0, 0, 1, targets[t], 32'h0);
            applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
            want_exc = (ADDR_CHECK && t != 2) ? 5'd4 : 5'd0;
            if (obs() !== expv() || d_pc !== targets[t] || d_exc_code !== want_exc) begin
                bad++;
                $display("[TB] FAIL addr_check[%h] got=%h want=%h", targets[t], obs(), expv());
            end
            total++;
        end
        // Falling off the end of the text segment right after the last legal word.
        applyStimulus(0, 0, 0, 1, 32'h0000_6FFC, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
        if (obs() !== expv() || d_pc !== 32'h0000_7000 || d_exc_code !== (ADDR_CHECK ? 5'd4 : 5'd0)) begin
            bad++;
            $display("[TB] FAIL addr_limit_step got=%h want=%h", obs(), expv());
        end
        total++;
    endtask

    task automatic test_wrap();
        applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
        if (obs() !== expv() || im_pc !== 32'h0 || d_pc8 !== 32'h0000_0004) begin
            bad++;
            $display("[TB] FAIL wrap got=%h want=%h", obs(), expv());
        end
        total++;
        applyStimulus(0, 1, 0, 0, 32'h0, 32'h0000_3000);
    endtask

    task automatic test_random();
        logic        e, er, st, rv;
        logic [31:0] rpc, ep;
        for (int i = 0; i < 400; i++) begin
            e  = ($urandom_range(0, 15) == 0);
            er = ($urandom_range(0, 15) == 0);
            st = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 4) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? 32'($urandom)
                                              : 32'h0000_3000 + 32'($urandom_range(0, 4095) * 4);
            ep  = ($urandom_range(0, 3) == 0) ? 32'($urandom)
                                              : 32'h0000_3000 + 32'($urandom_range(0, 4095) * 4);
            applyStimulus(e, er, st, rv, rpc, ep);
            if (obs() !== expv()) begin
                bad++;
                $display("[TB] FAIL random[%0d] got=%h want=%h", i, obs(), expv());
            end
            total++;
        end
    endtask

    task automatic test_reset_midstream();
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3400;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        if (obs() !== expv() || im_pc !== 32'h0000_3000 || d_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL async_reset got=%h want=%h", obs(), expv());
        end
        total++;
        @(negedge clk);
        stall          = 1'b0;
        redirect_valid = 1'b0;
        reset          = 1'b1;
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
        if (obs() !== expv() || im_pc !== 32'h0000_3004 || d_pc !== 32'h0000_3000) begin
            bad++;
            $display("[TB] FAIL reset_release got=%h want=%h", obs(), expv());
        end
        total++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_exception();
        test_eret();
        test_addr_check();
        test_wrap();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
